// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register and its entries.
package pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between a pipeline stage register and its neighbours.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 6
);
    import pipe_pkg::*;

    logic              flush_IN;
    logic              valid_IN;
    logic              ready_OUT;
    logic [DATA_W-1:0] data_IN;
    logic [CTRL_W-1:0] ctrl_IN;
    logic              valid_OUT;
    logic              ready_IN;
    logic [DATA_W-1:0] data_OUT;
    logic [CTRL_W-1:0] ctrl_OUT;
    logic [OCC_W-1:0]  occupancy_OUT;

    // master drives the stage (upstream + downstream environment), slave is the stage itself
    modport master (
        output flush_IN, valid_IN, data_IN, ctrl_IN, ready_IN,
        input  ready_OUT, valid_OUT, data_OUT, ctrl_OUT, occupancy_OUT
    );

    modport slave (
        input  flush_IN, valid_IN, data_IN, ctrl_IN, ready_IN,
        output ready_OUT, valid_OUT, data_OUT, ctrl_OUT, occupancy_OUT
    );

endinterface

// File: rtl/pipe_entry.sv
// One storage entry (valid + data + ctrl). clear_all beats clear_valid beats load;
// clear_valid keeps data so a flushed payload stays visible but can never strobe.
module pipe_entry #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 6
) (
    input  logic              clk,
    input  logic              load,
    input  logic              clear_valid,
    input  logic              clear_all,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    logic              valid_reg;
    logic [DATA_W-1:0] data_reg;
    logic [CTRL_W-1:0] ctrl_reg;

    always_ff @(posedge clk) begin
        if (clear_all) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            ctrl_reg  <= '0;
        end else if (clear_valid) begin
            valid_reg <= 1'b0;
            ctrl_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= d_data;
            ctrl_reg  <= d_ctrl;
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;
    assign ctrl  = ctrl_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with one-entry skid buffer, flush and bubble-gated control.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 6
) (
    input  logic             CLK,
    input  logic             RST,
    pipe_stage_reg_if.slave  bus
);

    state_t state_reg, state_next;

    logic              main_load, main_sel_skid, main_clr;
    logic              skid_load, skid_clr;
    logic              main_valid, skid_valid;
    logic [DATA_W-1:0] main_data, skid_data, main_d_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
    logic [OCC_W-1:0]  occ;

    always_ff @(posedge CLK) begin
        if (RST) state_reg <= ST_EMPTY;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (bus.flush_IN) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: if (bus.valid_IN) state_next = ST_BUSY;
                ST_BUSY: begin
                    if (bus.ready_IN && !bus.valid_IN)      state_next = ST_EMPTY;
                    else if (!bus.ready_IN && bus.valid_IN) state_next = ST_FULL;
                end
                ST_FULL:  if (bus.ready_IN) state_next = ST_BUSY;
                default:  state_next = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        main_load     = 1'b0;
        main_sel_skid = 1'b0;
        main_clr      = bus.flush_IN;
        skid_load     = 1'b0;
        skid_clr      = bus.flush_IN;
        occ           = '0;
        case (state_reg)
            ST_EMPTY: begin
                main_load = bus.valid_IN;
            end
            ST_BUSY: begin
                occ       = 2'd1;
                main_load = bus.ready_IN && bus.valid_IN;
                skid_load = !bus.ready_IN && bus.valid_IN;
                if (bus.ready_IN && !bus.valid_IN) main_clr = 1'b1;
            end
            ST_FULL: begin
                occ           = 2'd2;
                main_load     = bus.ready_IN;
                main_sel_skid = 1'b1;
                if (bus.ready_IN) skid_clr = 1'b1;
            end
            default: begin
                main_clr = 1'b1;
                skid_clr = 1'b1;
            end
        endcase
    end

    assign main_d_data = main_sel_skid ? skid_data : bus.data_IN;
    assign main_d_ctrl = main_sel_skid ? skid_ctrl : bus.ctrl_IN;

    pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk         (CLK),
        .load        (main_load),
        .clear_valid (main_clr),
        .clear_all   (RST),
        .d_data      (main_d_data),
        .d_ctrl      (main_d_ctrl),
        .valid       (main_valid),
        .data        (main_data),
        .ctrl        (main_ctrl)
    );

    pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk         (CLK),
        .load        (skid_load),
        .clear_valid (skid_clr),
        .clear_all   (RST),
        .d_data      (bus.data_IN),
        .d_ctrl      (bus.ctrl_IN),
        .valid       (skid_valid),
        .data        (skid_data),
        .ctrl        (skid_ctrl)
    );

    // skid valid is a flop that is set exactly in FULL, so ready has no path from any input
    assign bus.ready_OUT     = !skid_valid;
    assign bus.valid_OUT     = main_valid;
    assign bus.data_OUT      = main_data;
    assign bus.ctrl_OUT      = main_valid ? main_ctrl : '0;
    assign bus.occupancy_OUT = occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed + random bench for pipe_stage_reg against a two-deep FIFO reference model.
module tb_pipe_stage_reg;

    typedef struct {
        logic [15:0] d;
        logic [5:0]  c;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    ent_t q[$];
    logic [15:0] last_d;

    pipe_stage_reg_if #(.DATA_W(16), .CTRL_W(6)) bus ();

    pipe_stage_reg #(.DATA_W(16), .CTRL_W(6)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Called at the falling edge: drive, check outputs, advance the model across the rising edge.
    task automatic cycle(input bit r, input bit f, input bit v,
                         input logic [15:0] d, input logic [5:0] c, input bit rdy);
        bit   exp_ready;
        ent_t e;
        rst          = r;
        bus.flush_IN = f;
        bus.valid_IN = v;
        bus.data_IN  = d;
        bus.ctrl_IN  = c;
        bus.ready_IN = rdy;
        #1;
        exp_ready = (q.size() < 2);
        chk("valid_OUT", {31'd0, bus.valid_OUT}, {31'd0, q.size() > 0});
        chk("ready_OUT", {31'd0, bus.ready_OUT}, {31'd0, exp_ready});
        chk("occupancy", {30'd0, bus.occupancy_OUT}, q.size());
        chk("data_OUT", {16'd0, bus.data_OUT}, {16'd0, (q.size() > 0) ? q[0].d : last_d});
        chk("ctrl_OUT", {26'd0, bus.ctrl_OUT}, {26'd0, (q.size() > 0) ? q[0].c : 6'd0});
        $display("step r=%0d f=%0d v=%0d d=%h c=%h rdy=%0d | vout=%0b dout=%h cout=%h occ=%0d",
                 r, f, v, d, c, rdy, bus.valid_OUT, bus.data_OUT, bus.ctrl_OUT, bus.occupancy_OUT);
        @(posedge clk);
        if (r) begin
            q.delete();
            last_d = '0;
        end else begin
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (f) q.delete();
            else if (v && exp_ready) begin
                e.d = d;
                e.c = c;
                q.push_back(e);
            end
        end
        if (q.size() > 0) last_d = q[0].d;
        @(negedge clk);
    endtask

    task automatic fill_full();
        cycle(0, 0, 1, 16'h00AA, 6'h01, 0);
        cycle(0, 0, 1, 16'h00BB, 6'h02, 0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.flush_IN = 1'b0;
        bus.valid_IN = 1'b1;
        bus.data_IN  = 16'h1234;
        bus.ctrl_IN  = 6'h3F;
        bus.ready_IN = 1'b0;
        last_d       = '0;
        @(posedge clk);
        @(negedge clk);

        // reset held with live input
        cycle(1, 0, 1, 16'h1234, 6'h3F, 0);
        cycle(1, 0, 1, 16'h1234, 6'h3F, 0);
        cycle(0, 0, 0, 16'h0, 6'h0, 1);

        // streaming
        for (int i = 1; i <= 16; i++) cycle(0, 0, 1, i[15:0], i[5:0], 1);
        cycle(0, 0, 0, 16'h0, 6'h0, 1);
        cycle(0, 0, 0, 16'h0, 6'h0, 1);

        // stall / skid, C rejected while FULL
        cycle(0, 0, 1, 16'h00AA, 6'h01, 1);
        cycle(0, 0, 1, 16'h00BB, 6'h02, 0);
        cycle(0, 0, 1, 16'h00CC, 6'h03, 0);
        cycle(0, 0, 1, 16'h00CC, 6'h03, 1);
        cycle(0, 0, 1, 16'h00CC, 6'h03, 1);
        cycle(0, 0, 0, 16'h0, 6'h0, 1);
        cycle(0, 0, 0, 16'h0, 6'h0, 1);

        // flush in FULL with a live input
        fill_full();
        cycle(0, 1, 1, 16'h00DD, 6'h3F, 0);
        cycle(0, 0, 0, 16'h0, 6'h0, 1);
        cycle(0, 0, 0, 16'h0, 6'h0, 1);

        // flush in FULL while downstream takes main
        fill_full();
        cycle(0, 1, 1, 16'h00EE, 6'h3F, 1);
        cycle(0, 0, 0, 16'h0, 6'h0, 1);

        // bubble gating
        cycle(0, 0, 1, 16'h0055, 6'h21, 1);
        cycle(0, 0, 0, 16'h0, 6'h0, 1);
        cycle(0, 0, 0, 16'h0, 6'h0, 1);
        cycle(0, 0, 0, 16'h0, 6'h0, 1);

        // reset + flush collision in FULL
        fill_full();
        cycle(1, 1, 1, 16'h00FF, 6'h3F, 0);
        cycle(0, 0, 0, 16'h0, 6'h0, 0);

        // reset mid-stall
        fill_full();
        cycle(1, 0, 0, 16'h0, 6'h0, 0);
        cycle(0, 0, 1, 16'h0077, 6'h07, 0);
        cycle(0, 0, 0, 16'h0, 6'h0, 1);
        cycle(0, 0, 0, 16'h0, 6'h0, 1);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom % 64) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
                  16'($urandom), 6'($urandom), ($urandom % 3) != 0);
        end
        cycle(0, 0, 0, 16'h0, 6'h0, 1);
        cycle(0, 0, 0, 16'h0, 6'h0, 1);
        cycle(0, 0, 0, 16'h0, 6'h0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, a one-entry skid buffer, synchronous flush and bubble-safe control outputs. It replaces the fixed-field, always-loading inter-stage registers between decode, execute and writeback. It carries an opaque data payload plus a control vector (write enables, PC load, SPR strobes) that is guaranteed zero whenever no valid instruction is presented. Full throughput is one transfer per cycle; the registered `ready_OUT` breaks the combinational stall path.

## Interface
- `DATA_W`, default 16: payload width (operands, addresses, write register index).
- `CTRL_W`, default 6: control vector width. Every bit is an active-high strobe that is forced to 0 on a bubble.
- `CLK`, in, 1: single clock; all state changes on the rising edge.
- `RST`, in, 1: reset, synchronous, active-high.
- `flush_IN`, in, 1: synchronous kill of all held entries (branch taken / exception).
- `valid_IN`, in, 1: upstream presents an entry.
- `ready_OUT`, out, 1: stage can accept an entry. Registered.
- `data_IN`, in, `DATA_W`: upstream payload.
- `ctrl_IN`, in, `CTRL_W`: upstream control vector.
- `valid_OUT`, out, 1: entry presented downstream.
- `ready_IN`, in, 1: downstream accepts.
- `data_OUT`, out, `DATA_W`: head payload.
- `ctrl_OUT`, out, `CTRL_W`: head control vector, forced to 0 when `valid_OUT` = 0.
- `occupancy_OUT`, out, 2: number of held entries, 0 to 2.

## Operation
- Upstream transfer: `valid_IN && ready_OUT`. Downstream transfer: `valid_OUT && ready_IN`.
- Storage: a main entry (drives the outputs) and a skid entry. Each entry holds a valid bit, data and ctrl.
- States:
  - EMPTY: main invalid.
  - BUSY: main valid, skid invalid.
  - FULL: both valid.
- EMPTY:
  - `valid_IN` → load main → BUSY.
  - Otherwise stay in EMPTY.
- BUSY:
  - `ready_IN && valid_IN` → main ← input, stay in BUSY.
  - `ready_IN && !valid_IN` → EMPTY.
  - `!ready_IN && valid_IN` → skid ← input → FULL.
  - Neither → hold.
- FULL:
  - `ready_OUT` = 0; input is ignored.
  - `ready_IN` → main ← skid, skid invalid → BUSY.
- `ready_OUT` = 1 in EMPTY and BUSY, 0 in FULL.
- Entries leave in arrival order. No entry is duplicated or dropped except by flush or reset.
- Flush:
  - Priority over every handshake.
  - Next state EMPTY, both valid bits cleared, stored ctrl cleared.
  - Stored data is retained, not cleared.
  - An input presented in the flush cycle is discarded.
  - A downstream transfer in the flush cycle still completes, because the output was valid before the edge.
- Reset:
  - Same effect as flush.
  - Additionally clears both data registers to 0.
- `ctrl_OUT` = `valid_OUT ? main.ctrl : 0`, combinational gate, so a held or stale entry can never strobe a write.
- `occupancy_OUT`: EMPTY = 0, BUSY = 1, FULL = 2.

## Timing
- Reset values: `valid_OUT`=0, `ready_OUT`=1, `data_OUT`=0, `ctrl_OUT`=0, `occupancy_OUT`=0. All take effect on the first edge with `RST`=1.
- Latency: 1 cycle. An entry accepted at edge N appears on the outputs after edge N.
- All outputs depend only on registers, except the `ctrl_OUT` gate on `valid_OUT`. No input-to-output combinational path exists.
- `ready_OUT` falls one cycle after the cycle in which BUSY stalls and accepts. The skid entry absorbs the in-flight entry.
- `RST` and `flush_IN` both high: reset wins, giving data = 0.
- Flush in FULL with `ready_IN`=1: the main entry transfers out, the skid entry is discarded, and the next state is EMPTY.
- Reset mid-stall (FULL): both entries are lost and `ready_OUT`=1 on the next cycle.

## Structure
- Shared package `pipe_pkg` holds:
  - The state enum: `ST_EMPTY`, `ST_BUSY`, `ST_FULL`.
  - The occupancy width constant (2).
- Sub-module `pipe_entry`, instantiated twice (main and skid):
  - Parametrised by `DATA_W` and `CTRL_W`.
  - Inputs: load, clear_valid, clear_all.
  - Outputs: valid, data, ctrl.
- The top level contains only the state machine, the steering mux (input or skid into main) and the ctrl gate.

## Test plan
- Reset: assert `RST` for 2 cycles with `valid_IN`=1 and `data_IN`=0x1234 → `valid_OUT`=0, `data_OUT`=0, `ctrl_OUT`=0, `ready_OUT`=1, occupancy 0.
- Streaming: hold `ready_IN`=1 and send 0x0001 to 0x0010 on consecutive cycles → the same sequence appears one cycle later, with no gaps and occupancy 1 throughout.
- Stall/skid:
  - Stimulus: send A=0x00AA then B=0x00BB with `ready_IN`=0 from A's output cycle.
  - Required response: occupancy 2 and `ready_OUT`=0; C=0x00CC presented during FULL is not accepted.
  - Release: raise `ready_IN` → outputs A, then B, then C once re-presented.
- Flush:
  - Stimulus: in FULL, pulse `flush_IN` with `valid_IN`=1 and `ctrl_IN`=6'h3F.
  - Required response: next cycle `valid_OUT`=0, `ctrl_OUT`=0, occupancy 0, `ready_OUT`=1; the flushed-cycle input never appears.
- Bubble gating:
  - Stimulus: deliver one entry with `ctrl_IN`=6'h21, then `valid_IN`=0 and `ready_IN`=1.
  - Required response: `ctrl_OUT`=6'h21 for exactly one cycle, then 0, while `data_OUT` holds its last value.
- Reset/flush collision: assert `RST` and `flush_IN` together in FULL → data registers 0, occupancy 0.
